// File: rtl/s6ddr_initref.sv
// DDR SDRAM power-up / mode-register sequencer and periodic AUTO REFRESH source
// feeding the Spartan-6 PHY DFI command path (phase 0 carries commands, phase 1 is idle).
module s6ddr_initref #(
    parameter int                NUM_AD    = 13,
    parameter int                NUM_BA    = 2,
    parameter int                INIT_WAIT = 20000,
    parameter int                TRP       = 2,
    parameter int                TMRD      = 2,
    parameter int                TRFC      = 8,
    parameter int                TREFI     = 780,
    parameter logic [NUM_AD-1:0] MR        = 13'h032,
    parameter logic [NUM_AD-1:0] EMR       = 13'h000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ctl_idle,
    output logic              own_bus,
    output logic              init_done,
    output logic              ref_req,
    output logic              ref_overrun,
    output logic [NUM_AD-1:0] dfi_address_p0,
    output logic [NUM_AD-1:0] dfi_address_p1,
    output logic [NUM_BA-1:0] dfi_bank_p0,
    output logic [NUM_BA-1:0] dfi_bank_p1,
    output logic              dfi_cs_n_p0,
    output logic              dfi_cs_n_p1,
    output logic              dfi_ras_n_p0,
    output logic              dfi_ras_n_p1,
    output logic              dfi_cas_n_p0,
    output logic              dfi_cas_n_p1,
    output logic              dfi_we_n_p0,
    output logic              dfi_we_n_p1,
    output logic              dfi_cke_p0,
    output logic              dfi_cke_p1
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_DES = 4'b1111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam logic [15:0] WAIT_INIT = 16'(INIT_WAIT);
    localparam logic [15:0] TRP_M1    = 16'(TRP - 1);
    localparam logic [15:0] TMRD_M1   = 16'(TMRD - 1);
    localparam logic [15:0] TRFC_M1   = 16'(TRFC - 1);
    localparam logic [15:0] TREFI_M1  = 16'(TREFI - 1);
    localparam logic [3:0]  PEND_MAX  = 4'd8;

    localparam logic [NUM_AD-1:0] ADDR_A10 = NUM_AD'(1024);
    localparam logic [NUM_AD-1:0] ADDR_A8  = NUM_AD'(256);
    localparam logic [NUM_BA-1:0] BA_EMR   = NUM_BA'(1);

    // Each state names the action taken once the spacing counter has drained.
    typedef enum logic [3:0] {
        ST_CKE, ST_PRE0, ST_EMR, ST_MR_DLL, ST_PRE1,
        ST_AREF0, ST_AREF1, ST_MR, ST_DONE, ST_IDLE, ST_REF
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       waitCnt_q, waitCnt_d;
    logic [15:0]       timer_q, timer_d;
    logic [3:0]        pending_q, pending_d;
    logic              cke_q, cke_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [NUM_AD-1:0] addr_q, addr_d;
    logic [NUM_BA-1:0] bank_q, bank_d;
    logic              ownBus_q, ownBus_d;
    logic              initDone_q, initDone_d;
    logic              refReq_q, refReq_d;
    logic              overrun_q, overrun_d;
    logic              p1CsN_q;
    logic              expire;
    logic              refDec;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_CKE;
            waitCnt_q  <= WAIT_INIT;
            timer_q    <= TREFI_M1;
            pending_q  <= 4'd0;
            cke_q      <= 1'b0;
            cmd_q      <= CMD_DES;
            addr_q     <= '0;
            bank_q     <= '0;
            ownBus_q   <= 1'b1;
            initDone_q <= 1'b0;
            refReq_q   <= 1'b0;
            overrun_q  <= 1'b0;
            p1CsN_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            cke_q      <= cke_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            ownBus_q   <= ownBus_d;
            initDone_q <= initDone_d;
            refReq_q   <= refReq_d;
            overrun_q  <= overrun_d;
            p1CsN_q    <= ~cke_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = (waitCnt_q != 16'd0) ? waitCnt_q - 16'd1 : 16'd0;
        cke_d      = cke_q;
        cmd_d      = cke_q ? CMD_NOP : CMD_DES;
        addr_d     = '0;
        bank_d     = '0;
        ownBus_d   = ownBus_q;
        initDone_d = initDone_q;
        refDec     = 1'b0;

        if (waitCnt_q == 16'd0) begin
            case (state_q)
                ST_CKE: begin
                    cke_d   = 1'b1;
                    cmd_d   = CMD_NOP;
                    state_d = ST_PRE0;
                end
                ST_PRE0: begin
                    cmd_d     = CMD_PRE;
                    addr_d    = ADDR_A10;
                    waitCnt_d = TRP_M1;
                    state_d   = ST_EMR;
                end
                ST_EMR: begin
                    cmd_d     = CMD_LMR;
                    addr_d    = EMR;
                    bank_d    = BA_EMR;
                    waitCnt_d = TMRD_M1;
                    state_d   = ST_MR_DLL;
                end
                ST_MR_DLL: begin
                    cmd_d     = CMD_LMR;
                    addr_d    = MR | ADDR_A8;
                    waitCnt_d = TMRD_M1;
                    state_d   = ST_PRE1;
                end
                ST_PRE1: begin
                    cmd_d     = CMD_PRE;
                    addr_d    = ADDR_A10;
                    waitCnt_d = TRP_M1;
                    state_d   = ST_AREF0;
                end
                ST_AREF0: begin
                    cmd_d     = CMD_REF;
                    waitCnt_d = TRFC_M1;
                    state_d   = ST_AREF1;
                end
                ST_AREF1: begin
                    cmd_d     = CMD_REF;
                    waitCnt_d = TRFC_M1;
                    state_d   = ST_MR;
                end
                ST_MR: begin
                    cmd_d     = CMD_LMR;
                    addr_d    = MR & ~ADDR_A8;
                    waitCnt_d = TMRD_M1;
                    state_d   = ST_DONE;
                end
                ST_DONE: begin
                    initDone_d = 1'b1;
                    ownBus_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
                ST_IDLE: begin
                    if ((pending_q != 4'd0) && ctl_idle) begin
                        cmd_d     = CMD_PRE;
                        addr_d    = ADDR_A10;
                        ownBus_d  = 1'b1;
                        waitCnt_d = TRP_M1;
                        state_d   = ST_REF;
                    end
                end
                ST_REF: begin
                    if (pending_q != 4'd0) begin
                        cmd_d     = CMD_REF;
                        refDec    = 1'b1;
                        waitCnt_d = TRFC_M1;
                    end else begin
                        ownBus_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_CKE;
            endcase
        end

        // An expiry landing on the same cycle as a burst AREF cancels out.
        expire    = initDone_q && (timer_q == 16'd0);
        timer_d   = timer_q;
        if (initDone_q) begin
            timer_d = expire ? TREFI_M1 : timer_q - 16'd1;
        end
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (expire && !refDec) begin
            if (pending_q == PEND_MAX) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = pending_q + 4'd1;
            end
        end else if (refDec && !expire) begin
            pending_d = pending_q - 4'd1;
        end

        refReq_d = initDone_d && (pending_d != 4'd0) && !ownBus_d;
    end

    assign {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} = cmd_q;
    assign dfi_address_p0 = addr_q;
    assign dfi_bank_p0    = bank_q;
    assign dfi_cke_p0     = cke_q;

    assign dfi_cs_n_p1    = p1CsN_q;
    assign dfi_ras_n_p1   = 1'b1;
    assign dfi_cas_n_p1   = 1'b1;
    assign dfi_we_n_p1    = 1'b1;
    assign dfi_address_p1 = '0;
    assign dfi_bank_p1    = '0;
    assign dfi_cke_p1     = cke_q;

    assign own_bus     = ownBus_q;
    assign init_done   = initDone_q;
    assign ref_req     = refReq_q;
    assign ref_overrun = overrun_q;

endmodule

// File: tb/tb_s6ddr_initref.sv
// Self-checking bench for s6ddr_initref: random ctl_idle/reset stimulus against a
// cycle-indexed reference model built from the command schedule and refresh rules.
module tb_s6ddr_initref;

    localparam int          NUM_AD    = 13;
    localparam int          NUM_BA    = 2;
    localparam int          INIT_WAIT = 10;
    localparam int          TRP       = 2;
    localparam int          TMRD      = 3;
    localparam int          TRFC      = 4;
    localparam int          TREFI     = 40;
    localparam logic [12:0] MR        = 13'h032;
    localparam logic [12:0] EMR       = 13'h000;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] DES  = 4'b1111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              ctl_idle;
    logic              own_bus, init_done, ref_req, ref_overrun;
    logic [NUM_AD-1:0] dfi_address_p0, dfi_address_p1;
    logic [NUM_BA-1:0] dfi_bank_p0, dfi_bank_p1;
    logic              dfi_cs_n_p0, dfi_cs_n_p1, dfi_ras_n_p0, dfi_ras_n_p1;
    logic              dfi_cas_n_p0, dfi_cas_n_p1, dfi_we_n_p0, dfi_we_n_p1;
    logic              dfi_cke_p0, dfi_cke_p1;

    always #5 sys_clk = ~sys_clk;

    s6ddr_initref #(
        .NUM_AD(NUM_AD), .NUM_BA(NUM_BA), .INIT_WAIT(INIT_WAIT), .TRP(TRP),
        .TMRD(TMRD), .TRFC(TRFC), .TREFI(TREFI), .MR(MR), .EMR(EMR)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ctl_idle(ctl_idle),
        .own_bus(own_bus), .init_done(init_done), .ref_req(ref_req), .ref_overrun(ref_overrun),
        .dfi_address_p0(dfi_address_p0), .dfi_address_p1(dfi_address_p1),
        .dfi_bank_p0(dfi_bank_p0), .dfi_bank_p1(dfi_bank_p1),
        .dfi_cs_n_p0(dfi_cs_n_p0), .dfi_cs_n_p1(dfi_cs_n_p1),
        .dfi_ras_n_p0(dfi_ras_n_p0), .dfi_ras_n_p1(dfi_ras_n_p1),
        .dfi_cas_n_p0(dfi_cas_n_p0), .dfi_cas_n_p1(dfi_cas_n_p1),
        .dfi_we_n_p0(dfi_we_n_p0), .dfi_we_n_p1(dfi_we_n_p1),
        .dfi_cke_p0(dfi_cke_p0), .dfi_cke_p1(dfi_cke_p1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cycle index since reset release plus a few counters.
    int          mCyc;
    int          mPend;
    int          mNext;
    bit          mOver, mOwn, mDone, mBurst, mCke, mReq;
    logic [3:0]  mCmd;
    logic [12:0] mAddr;
    logic [1:0]  mBank;

    int          schedCyc[7];
    logic [3:0]  schedCmd[7];
    logic [12:0] schedAddr[7];
    logic [1:0]  schedBank[7];
    int          initDoneCyc;

    logic        rndIdle, rndRst, quietMode;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, mCyc, observed, expected);
        end
    endtask

    function automatic void buildSchedule();
        int t;
        t = INIT_WAIT + 1;
        schedCyc[0] = t; schedCmd[0] = PRE; schedAddr[0] = 13'h400;       schedBank[0] = 2'd0; t += TRP;
        schedCyc[1] = t; schedCmd[1] = LMR; schedAddr[1] = EMR;           schedBank[1] = 2'd1; t += TMRD;
        schedCyc[2] = t; schedCmd[2] = LMR; schedAddr[2] = MR | 13'h100;  schedBank[2] = 2'd0; t += TMRD;
        schedCyc[3] = t; schedCmd[3] = PRE; schedAddr[3] = 13'h400;       schedBank[3] = 2'd0; t += TRP;
        schedCyc[4] = t; schedCmd[4] = AREF; schedAddr[4] = 13'h000;      schedBank[4] = 2'd0; t += TRFC;
        schedCyc[5] = t; schedCmd[5] = AREF; schedAddr[5] = 13'h000;      schedBank[5] = 2'd0; t += TRFC;
        schedCyc[6] = t; schedCmd[6] = LMR; schedAddr[6] = MR & ~13'h100; schedBank[6] = 2'd0; t += TMRD;
        initDoneCyc = t;
    endfunction

    function automatic void modelStep(input logic idleIn, input logic rstIn);
        bit expiry, aref;
        if (!rstIn) begin
            mCyc = -1; mPend = 0; mNext = 0;
            mOver = 0; mOwn = 1; mDone = 0; mBurst = 0; mCke = 0; mReq = 0;
            mCmd = DES; mAddr = '0; mBank = '0;
            return;
        end
        mCyc++;
        mAddr = '0;
        mBank = '0;
        aref  = 0;
        if (mCyc < initDoneCyc) begin
            mCke = (mCyc >= INIT_WAIT);
            mCmd = mCke ? NOP : DES;
            for (int i = 0; i < 7; i++) begin
                if (mCyc == schedCyc[i]) begin
                    mCmd = schedCmd[i]; mAddr = schedAddr[i]; mBank = schedBank[i];
                end
            end
        end else begin
            mCke   = 1;
            mDone  = 1;
            mCmd   = NOP;
            expiry = (mCyc > initDoneCyc) && (((mCyc - initDoneCyc) % TREFI) == 0);
            if (mCyc == initDoneCyc) begin
                mOwn = 0;
            end else if (!mBurst) begin
                if (mPend != 0 && idleIn) begin
                    mCmd = PRE; mAddr = 13'h400; mOwn = 1; mBurst = 1; mNext = mCyc + TRP;
                end
            end else if (mCyc == mNext) begin
                if (mPend != 0) begin
                    mCmd = AREF; aref = 1; mNext = mCyc + TRFC;
                end else begin
                    mOwn = 0; mBurst = 0;
                end
            end
            if (expiry && !aref) begin
                if (mPend == 8) mOver = 1;
                else mPend++;
            end else if (aref && !expiry) begin
                mPend--;
            end
        end
        mReq = mDone && (mPend != 0) && !mOwn;
    endfunction

    task automatic applyStimulus(input logic idleIn, input logic rstIn);
        ctl_idle  = idleIn;
        sys_rst_n = rstIn;
        @(posedge sys_clk);
        modelStep(idleIn, rstIn);
        @(negedge sys_clk);
        checkOutput("cke_p0", 32'(dfi_cke_p0), 32'(mCke));
        checkOutput("cke_p1", 32'(dfi_cke_p1), 32'(mCke));
        checkOutput("cmd_p0", 32'({dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0}), 32'(mCmd));
        checkOutput("addr_p0", 32'(dfi_address_p0), 32'(mAddr));
        checkOutput("bank_p0", 32'(dfi_bank_p0), 32'(mBank));
        checkOutput("cmd_p1", 32'({dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1}),
                    32'(mCke ? NOP : DES));
        checkOutput("addrbank_p1", 32'({dfi_address_p1, dfi_bank_p1}), 32'd0);
        checkOutput("own_bus", 32'(own_bus), 32'(mOwn));
        checkOutput("init_done", 32'(init_done), 32'(mDone));
        checkOutput("ref_req", 32'(ref_req), 32'(mReq));
        checkOutput("ref_overrun", 32'(ref_overrun), 32'(mOver));
    endtask

    initial begin
        buildSchedule();
        sys_rst_n = 1'b0;
        ctl_idle  = 1'b0;
        mCyc      = -1;
        @(negedge sys_clk);

        // Init sequence, then a single refresh with the controller always idle.
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (101) applyStimulus(1'b1, 1'b1);

        // Open the bus so the first burst AREF lands on a timer expiry.
        repeat (2) applyStimulus(1'b1, 1'b0);
        repeat (110) applyStimulus(1'b0, 1'b1);
        repeat (25) applyStimulus(1'b1, 1'b1);

        // Starve the block until the pending count saturates, then drain it.
        repeat (9 * TREFI) applyStimulus(1'b0, 1'b1);
        repeat (50) applyStimulus(1'b1, 1'b1);

        // Reset in the middle of a burst, then the full init must rerun.
        repeat (100) applyStimulus(1'b0, 1'b1);
        repeat (8) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        repeat (45) applyStimulus(1'b1, 1'b1);

        quietMode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 60) == 0) quietMode = ($urandom_range(0, 2) == 0);
            rndIdle = quietMode ? 1'b0 : ($urandom_range(0, 3) != 0);
            rndRst  = ($urandom_range(0, 499) != 0);
            applyStimulus(rndIdle, rndRst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
